// File: rtl/nibble_serial_sub_seq_if.sv
// ============================================================================
// Module      : nibble_serial_sub_seq_if
// Description : Operand/result bus and 4-bit subtractor link for the
//               nibble-serial subtraction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nibble_serial_sub_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int c_W = 4 * NIBBLES;

    logic           start;
    logic [c_W-1:0] op_a;
    logic [c_W-1:0] op_b;
    logic [3:0]     sub_a;
    logic [3:0]     sub_b;
    logic           sub_cin;
    logic [3:0]     sub_s;
    logic           sub_cout;
    logic [c_W-1:0] result;
    logic           no_borrow;
    logic           zero;
    logic           negative;
    logic           overflow;
    logic           busy;
    logic           done;

    modport master (
        input  start, op_a, op_b, sub_s, sub_cout,
        output sub_a, sub_b, sub_cin, result, no_borrow, zero, negative,
               overflow, busy, done
    );

    modport slave (
        output start, op_a, op_b, sub_s, sub_cout,
        input  sub_a, sub_b, sub_cin, result, no_borrow, zero, negative,
               overflow, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_sub_seq.sv
// ============================================================================
// Module      : nibble_serial_sub_seq
// Description : Multi-precision A - B computed one nibble per clock through an
//               external 4-bit ripple subtractor; assembles result and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_sub_seq #(
    parameter int NIBBLES = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    nibble_serial_sub_seq_if.master     bus
);
    localparam int c_W  = 4 * NIBBLES;
    localparam int c_IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_run;
    logic            w_last;

    logic [c_W-1:0]  r_a_sh;
    logic [c_W-1:0]  r_b_sh;
    logic [c_W-1:0]  r_acc;
    logic [c_W-1:0]  w_acc_nxt;
    logic [c_IW-1:0] r_idx;
    logic            r_carry;
    logic [c_W-1:0]  r_result;
    logic            r_no_borrow;
    logic            r_zero;
    logic            r_negative;
    logic            r_overflow;
    logic            w_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_run       = 1'b0;
        w_last      = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.sub_a   = 4'd0;
        bus.sub_b   = 4'd0;
        bus.sub_cin = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                bus.done = (r_state == S_DONE);
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                bus.busy    = 1'b1;
                w_run       = 1'b1;
                bus.sub_a   = r_a_sh[3:0];
                bus.sub_b   = r_b_sh[3:0];
                bus.sub_cin = r_carry;
                if (r_idx == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The final nibble is merged here so flags see the complete result on the last edge.
    always_comb begin
        w_acc_nxt                        = r_acc;
        w_acc_nxt[{r_idx, 2'b00} +: 4]   = bus.sub_s;
        w_ovf = (r_a_sh[3] != r_b_sh[3]) && (bus.sub_s[3] != r_a_sh[3]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_no_borrow <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= bus.op_a;
            r_b_sh  <= bus.op_b;
            r_idx   <= '0;
            r_carry <= 1'b1;
        end else if (w_run) begin
            r_acc   <= w_acc_nxt;
            r_carry <= bus.sub_cout;
            r_a_sh  <= r_a_sh >> 4;
            r_b_sh  <= r_b_sh >> 4;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_result    <= w_acc_nxt;
                r_no_borrow <= bus.sub_cout;
                r_negative  <= bus.sub_s[3];
                r_zero      <= (w_acc_nxt == '0);
                r_overflow  <= w_ovf;
            end
        end
    end

    assign bus.result    = r_result;
    assign bus.no_borrow = r_no_borrow;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_negative;
    assign bus.overflow  = r_overflow;
endmodule

`default_nettype wire

// File: doc/nibble_serial_sub_seq.md
Name: nibble_serial_sub_seq

Overview:
Sequencer that performs a multi-precision subtraction A - B by driving the team's 4-bit ripple subtractor one nibble per clock.
- Sits directly upstream of the 4-bit subtractor. It latches the wide operands, presents one nibble pair plus the carry-in each cycle, and consumes the subtractor's sum and carry-out.
- Assembles the wide result and the ALU status flags for the downstream result register.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES (default 16). Legal range 1..16.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a subtraction; accepted only when busy=0
op_a  input  W  minuend, sampled on the accepting edge
op_b  input  W  subtrahend, sampled on the accepting edge
sub_a  output  4  current minuend nibble to the subtractor
sub_b  output  4  current subtrahend nibble to the subtractor (un-inverted; the subtractor inverts internally)
sub_cin  output  1  carry-in to the subtractor
sub_s  input  4  difference nibble returned by the subtractor (combinational from sub_a/sub_b/sub_cin)
sub_cout  input  1  carry-out returned by the subtractor; 1 = no borrow
result  output  W  A - B modulo 2^W
no_borrow  output  1  final carry-out; 1 when A >= B unsigned
zero  output  1  result == 0
negative  output  1  result[W-1]
overflow  output  1  signed overflow of A - B
busy  output  1  1 while in RUN
done  output  1  one-cycle pulse when result and flags become valid

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, nibble index=0, operand and carry registers=0, result=0, all flags=0, busy=0, done=0. Reset overrides everything, including mid-RUN; the partial result is discarded and no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Latch op_a/op_b into shift registers; index <= 0; carry <= 1 (two's-complement +1).
  - Go to RUN. busy rises the next cycle.
- IDLE/DONE with start=0: go to / stay in IDLE.
- RUN outputs (combinational from registers): sub_a = a_shift[3:0], sub_b = b_shift[3:0], sub_cin = carry. In IDLE/DONE these are held at 0.
- RUN, each edge:
  - result nibble[index] <= sub_s; carry <= sub_cout.
  - Shift a_shift and b_shift right by 4 (zero fill); index++.
- RUN exit: on the edge where index == NIBBLES-1, go to DONE. RUN therefore lasts exactly NIBBLES cycles.
- Flags, registered on the same edge as the last nibble:
  - no_borrow <= sub_cout.
  - negative <= sub_s[3].
  - zero <= (assembled result == 0).
  - overflow <= (a_msb != b_msb) && (sub_s[3] != a_msb), where a_msb/b_msb are bit 3 of the final nibbles.
- DONE lasts one cycle with done=1. Result and flags stay stable until the next accepted start or reset.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+NIBBLES.
- A start in the DONE cycle is accepted, giving back-to-back operations with one cycle between done pulses.
- start while busy=1 is ignored. Operands are not resampled and the operation in flight is unaffected.
- op_a/op_b may change freely after the accepting edge.
- result/flags are updated only at completion; intermediate nibbles are written into an internal accumulator that is copied to result on the final edge.

Test Plan:
1. NIBBLES=4, A=0x1234, B=0x0234, start pulse -> busy for 4 cycles, done 5 cycles after the start edge; result=0x1000, no_borrow=1, zero=0, negative=0, overflow=0.
2. A=0x0000, B=0x0001 -> result=0xFFFF, no_borrow=0, negative=1, overflow=0; sub_cin=1 on nibble 0 and 0 thereafter.
3. A=0x8000, B=0x0001 -> result=0x7FFF, overflow=1, negative=0, no_borrow=1. Also A=0x7FFF, B=0xFFFF -> result=0x8000, overflow=1.
4. A=B=0xBEEF -> result=0x0000, zero=1, no_borrow=1. Then start asserted in the DONE cycle with A=5, B=3 -> second done pulse 5 cycles later with result=0x0002.
5. Start A=0x1111, B=0x0001; hold start high and change operands to 0xFFFF/0xFFFF during RUN -> result=0x1110, exactly one done pulse.
6. rst=1 on the 2nd RUN cycle -> next cycle busy=0, done=0, result=0, all flags=0; no done pulse afterwards; a fresh start completes normally.
